// File: rtl/bus_pkg.sv
// Shared types and defaults for the data-side bus decoder.
// Holds the FSM state encoding, the default region map and the
// one-hot write-strobe helper used by data_bus_decoder.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } bus_state_t;

    localparam int BUS_AW       = 32;
    localparam int BUS_DW       = 32;
    localparam int BUS_N_REGION = 3;

    // Region 0 = data ROM, 1 = histogram RAM, 2 = image RAM (index 0 is the LSB slice).
    localparam logic [BUS_N_REGION*BUS_AW-1:0] BUS_REGION_BASE =
        {32'h0001_0000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [BUS_N_REGION*BUS_AW-1:0] BUS_REGION_MASK =
        {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_F000};

    // One-hot strobe for region sel; bits at or above n stay clear.
    function automatic logic [7:0] onehot_we(input logic [2:0] sel, input int n);
        logic [7:0] oh;
        oh = '0;
        if (int'(sel) < n) oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder: compares the address against
// every region's base/mask and reports the lowest-index hit together with
// the region-relative offset.
module bus_addr_decode #(
    parameter int N_REGION = 3,
    parameter int AW       = 32,
    parameter int SW       = 2,
    parameter logic [N_REGION*AW-1:0] REGION_BASE = '0,
    parameter logic [N_REGION*AW-1:0] REGION_MASK = '0
) (
    input  logic [AW-1:0] cpuAddr,
    output logic          hit,
    output logic [SW-1:0] sel,
    output logic [AW-1:0] offset
);

    // Scan from the highest index down so the lowest matching region overrides.
    always_comb begin
        hit    = 1'b0;
        sel    = '0;
        offset = cpuAddr & ~REGION_MASK[AW-1:0];
        for (int i = N_REGION - 1; i >= 0; i--) begin
            if ((cpuAddr & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]) begin
                hit    = 1'b1;
                sel    = SW'(i);
                offset = cpuAddr & ~REGION_MASK[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/data_bus_decoder.sv
// Data-side interconnect between the core's data port and N_REGION
// memory-mapped synchronous memories. Each access is sequenced through
// IDLE -> ACCESS -> (WAIT) -> RESP, or IDLE -> ERR on an unmapped address.
// Handshake: cpu_req is sampled only in IDLE; the access completes with a
// single-cycle cpu_ready pulse (cpu_err qualifies it); requests seen while
// busy are dropped, never queued.
// Optional feature: define DATA_BUS_PERF_CNT_EN to add per-region access
// counters (perf_cnt) and an error counter (err_cnt).
module data_bus_decoder
    import bus_pkg::*;
#(
    parameter int N_REGION = BUS_N_REGION,
    parameter int AW       = BUS_AW,
    parameter int DW       = BUS_DW,
    parameter int READ_LAT = 1,
    parameter logic [N_REGION*AW-1:0] REGION_BASE = BUS_REGION_BASE,
    parameter logic [N_REGION*AW-1:0] REGION_MASK = BUS_REGION_MASK
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [N_REGION-1:0]    mem_we,
    input  logic [N_REGION*DW-1:0] mem_rdata,
`ifdef DATA_BUS_PERF_CNT_EN
    output logic [N_REGION*32-1:0] perf_cnt,
    output logic [15:0]            err_cnt,
`endif
    output bus_state_t             dbgState
);

    localparam int SW = (N_REGION > 1) ? $clog2(N_REGION) : 1;

    bus_state_t    stateQ, stateD;
    logic          decHit;
    logic [SW-1:0] decSel;
    logic [AW-1:0] decOffset;
    logic [SW-1:0] selQ;
    logic          weQ;
    logic [DW-1:0] wdataQ;
    logic [AW-1:0] memAddrQ;
    logic [2:0]    cntQ;
    logic [DW-1:0] rdataQ;
    logic [7:0]    weOneHot;
    logic          accept;

    bus_addr_decode #(
        .N_REGION    (N_REGION),
        .AW          (AW),
        .SW          (SW),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .cpuAddr (cpu_addr),
        .hit     (decHit),
        .sel     (decSel),
        .offset  (decOffset)
    );

    assign accept = (stateQ == IDLE) && cpu_req;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) stateQ <= IDLE;
        else       stateQ <= stateD;
    end

    // Next-state logic: reads wait until the latency counter reaches its last cycle.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (cpu_req) stateD = decHit ? ACCESS : ERR;
            ACCESS:  stateD = weQ ? RESP : WAIT;
            WAIT:    if (cntQ <= 3'd1) stateD = RESP;
            RESP:    stateD = IDLE;
            ERR:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Request latches, latency counter and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            selQ     <= '0;
            weQ      <= 1'b0;
            wdataQ   <= '0;
            memAddrQ <= '0;
            cntQ     <= '0;
            rdataQ   <= '0;
        end else begin
            if (accept) begin
                selQ     <= decSel;
                weQ      <= cpu_we;
                wdataQ   <= cpu_wdata;
                memAddrQ <= decOffset;
                if (!decHit) rdataQ <= '0;
            end
            if (stateQ == ACCESS && !weQ) begin
                cntQ <= 3'(READ_LAT);
            end else if (stateQ == WAIT) begin
                cntQ <= cntQ - 3'd1;
                if (cntQ <= 3'd1) rdataQ <= mem_rdata[int'(selQ)*DW +: DW];
            end
        end
    end

    // Outputs decoded from the current state; the write strobe lives only in ACCESS.
    always_comb begin
        weOneHot  = onehot_we(3'(selQ), N_REGION);
        mem_we    = '0;
        if (stateQ == ACCESS && weQ) mem_we = weOneHot[N_REGION-1:0];
        cpu_ready = (stateQ == RESP) || (stateQ == ERR);
        cpu_err   = (stateQ == ERR);
        cpu_rdata = rdataQ;
        mem_addr  = memAddrQ;
        mem_wdata = wdataQ;
        dbgState  = stateQ;
    end

`ifdef DATA_BUS_PERF_CNT_EN
    // Saturating per-region completion counters and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (stateQ == RESP && perf_cnt[int'(selQ)*32 +: 32] != 32'hFFFF_FFFF)
                perf_cnt[int'(selQ)*32 +: 32] <= perf_cnt[int'(selQ)*32 +: 32] + 32'd1;
            if (stateQ == ERR && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
